axi4_burst_master: RTL

AXI4 master traffic engine sitting directly upstream of the AXI4 memory slave on the `memory_interface` bus. It accepts single-word burst commands from a simple valid/ready command port. It then executes one INCR write or read burst per command on the AXI4 channels. Write data is generated from a seed; read beats are streamed out, and a completion pulse reports the merged response.

---
 rtl/axi4_burst_pkg.sv | 36 +++
 rtl/axi4_burst_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_pkg.sv
// Types, AXI encodings and burst legality helpers for the AXI4 burst master.
package axi4_burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [13:0] PAGE_BYTES = 14'd4096;

    // Illegal when misaligned or when the byte after the burst lies beyond the 4 KB page.
    function automatic logic cmd_illegal(input logic [11:0] addr_lo, input logic [7:0] len);
        logic [13:0] end_byte;
        end_byte = {2'b00, addr_lo} + {4'b0000, len, 2'b00} + 14'd4;
        return (addr_lo[1:0] != 2'b00) || (end_byte > PAGE_BYTES);
    endfunction

    // Responses are ordered so that the numerically larger one is the more severe.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// AXI4 master that turns one command into one INCR write or read burst and
// reports the merged response with a single-cycle done pulse.
module axi4_burst_master
    import axi4_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [31:0]           cmd_seed,

    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,

    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [3:0]            WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,

    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,

    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,

    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,

    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,

    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  done_err
);

    state_t      state;
    logic [7:0]  len_q;
    logic [31:0] seed_q;
    logic [7:0]  beat;
    logic [1:0]  resp_acc;

    // NOTE: every output is a flop written with <= here, so no xREADY input
    // ever reaches an output combinationally and no latch can be inferred.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            seed_q    <= '0;
            beat      <= '0;
            resp_acc  <= RESP_OKAY;
            cmd_ready <= 1'b0;
            AWADDR    <= '0;
            AWLEN     <= '0;
            AWSIZE    <= '0;
            AWBURST   <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WSTRB     <= '0;
            WLAST     <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= '0;
            ARLEN     <= '0;
            ARSIZE    <= '0;
            ARBURST   <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            done      <= 1'b0;
            done_resp <= RESP_OKAY;
            done_err  <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        len_q     <= cmd_len;
                        seed_q    <= cmd_seed;
                        // Rejected commands skip the bus entirely.
                        if (cmd_illegal(cmd_addr[11:0], cmd_len)) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            done_resp <= RESP_SLVERR;
                            done_err  <= 1'b1;
                        end else if (cmd_write) begin
                            state   <= ST_WADDR;
                            AWADDR  <= cmd_addr;
                            AWLEN   <= cmd_len;
                            AWSIZE  <= SIZE_4B;
                            AWBURST <= BURST_INCR;
                            AWVALID <= 1'b1;
                        end else begin
                            state   <= ST_RADDR;
                            ARADDR  <= cmd_addr;
                            ARLEN   <= cmd_len;
                            ARSIZE  <= SIZE_4B;
                            ARBURST <= BURST_INCR;
                            ARVALID <= 1'b1;
                        end
                    end
                end

                ST_WADDR: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        WVALID  <= 1'b1;
                        WDATA   <= DATA_WIDTH'(seed_q);
                        WSTRB   <= 4'hF;
                        WLAST   <= (len_q == 8'd0);
                        beat    <= 8'd0;
                        state   <= ST_WDATA;
                    end
                end

                ST_WDATA: begin
                    if (WREADY) begin
                        if (WLAST) begin
                            WVALID <= 1'b0;
                            WLAST  <= 1'b0;
                            BREADY <= 1'b1;
                            state  <= ST_WRESP;
                        end else begin
                            beat  <= beat + 8'd1;
                            WDATA <= DATA_WIDTH'(seed_q + 32'(beat) + 32'd1);
                            WLAST <= ((beat + 8'd1) == len_q);
                        end
                    end
                end

                ST_WRESP: begin
                    if (BVALID) begin
                        BREADY    <= 1'b0;
                        done      <= 1'b1;
                        done_resp <= BRESP;
                        done_err  <= 1'b0;
                        state     <= ST_DONE;
                    end
                end

                ST_RADDR: begin
                    if (ARREADY) begin
                        ARVALID  <= 1'b0;
                        RREADY   <= 1'b1;
                        beat     <= 8'd0;
                        resp_acc <= RESP_OKAY;
                        state    <= ST_RDATA;
                    end
                end

                ST_RDATA: begin
                    if (RVALID) begin
                        rd_valid <= 1'b1;
                        rd_data  <= RDATA;
                        rd_last  <= RLAST;
                        // An early or missing RLAST still ends the burst, flagged as an error.
                        if (RLAST || (beat == len_q)) begin
                            RREADY    <= 1'b0;
                            done      <= 1'b1;
                            done_resp <= resp_max(resp_acc, RRESP);
                            done_err  <= (RLAST != (beat == len_q));
                            state     <= ST_DONE;
                        end else begin
                            beat     <= beat + 8'd1;
                            resp_acc <= resp_max(resp_acc, RRESP);
                        end
                    end
                end

                ST_DONE: begin
                    done_err  <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
